pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised successor to the single-register program counter. Holds the fetch PC and selects the next PC from sequential increment, branch target or a small hardware return-address stack (RAS). It supports stall and exposes RAS status flags. It sits between the branch/decode control logic and instruction memory in the single-cycle datapath.

Parameters:
W, 32, PC/address width in bits
INC, 4, sequential increment added to the PC each advancing cycle
RESET_VECTOR, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
reset_asynchronous  input  1  asynchronous, active-high reset
stall  input  1  hold PC and RAS unchanged this cycle
branch_taken  input  1  redirect to branch_target
branch_target  input  W  redirect address
call  input  1  push return address (pc+INC); qualified by branch_taken
ret  input  1  pop RAS and redirect to popped address
pc  output  W  current fetch address
pc_plus_inc  output  W  combinational pc+INC (mod 2^W)
ras_empty  output  1  RAS holds 0 entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_overflow  output  1  sticky: a push occurred while full
ras_underflow  output  1  sticky: a pop occurred while empty
misalign_fault  output  1  sticky alignment fault (see Optional Feature)

Behaviour:
- Reset is asynchronous. While asserted: pc=RESET_VECTOR, RAS count=0, all sticky flags=0, ras_empty=1, ras_full=0. RAS entry contents are don't-care. Reset mid-operation discards any in-flight push or pop.
- All state updates happen on the rising clk edge. There is one cycle of latency from control inputs to the new pc.
- Next-PC priority, highest first:
  1. stall=1: pc, RAS and flags hold. call/ret/branch are ignored.
  2. ret=1 and RAS non-empty: pc<=top entry; count-1.
  3. ret=1 and RAS empty: pc<=pc+INC; ras_underflow<=1.
  4. branch_taken=1: pc<=branch_target.
  5. otherwise: pc<=pc+INC.
- Push: call=1 with branch_taken=1 and not stalled pushes pc+INC; pc<=branch_target. call without branch_taken is ignored.
- call+branch_taken+ret in the same cycle (swap):
  - RAS non-empty: pc<=top; top entry overwritten with pc+INC; count unchanged.
  - RAS empty: push pc+INC, pc<=branch_target, ras_underflow<=1.
- Push while full: circular, the oldest entry is overwritten; count stays RAS_DEPTH; ras_overflow<=1.
- Arithmetic: pc+INC wraps modulo 2^W. No carry-out is kept.
- ras_empty and ras_full are decoded combinationally from the registered count.
- Sticky flags clear only on reset.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: any accepted redirect (branch target or popped RAS value) whose low log2(INC) bits are nonzero has those bits forced to zero before loading pc, and misalign_fault<=1 (sticky).
- Undefined: redirects load unmodified and misalign_fault is tied to 0.
- The port exists in both builds.

Decomposition:
- Shared package: next-PC select encoding (SEL_HOLD, SEL_RET, SEL_SEQ, SEL_BR), default INC/RESET_VECTOR constants, and a clog2 helper for the RAS pointer width.
- Sub-module return_stack: parametrised W×RAS_DEPTH circular stack with push/pop/swap inputs, top output, count, full/empty, and overflow/underflow pulses. pc_sequencer instantiates it and owns the sticky flags.

Test Plan:
- Reset with RESET_VECTOR=0x100, then 3 free-running cycles -> pc=0x100,0x104,0x108,0x10C; ras_empty=1; all flags 0.
- At pc=0x20, call+branch_taken with target 0x80 -> pc=0x80, RAS top=0x24. At pc=0x84, ret -> pc=0x24, ras_empty=1.
- 5 calls with RAS_DEPTH=4 (returns 0x04..0x14) -> ras_full=1, ras_overflow=1. 4 rets yield 0x14,0x10,0x0C,0x08. A 5th ret -> pc advances by INC, ras_underflow=1.
- stall=1 with branch_taken, call and ret all asserted for 2 cycles -> pc and count unchanged. On release, the branch applies.
- Assert reset_asynchronous between clock edges while a push is pending -> pc=RESET_VECTOR immediately, with no clock edge; count=0.
- With PC_ALIGN_CHECK_EN defined, branch to 0x8A -> pc=0x88, misalign_fault=1 and stays 1. Without the macro -> pc=0x8A, misalign_fault=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared next-PC select encoding, defaults and clog2 helper
package pc_sequencer_pkg;

   // Source of the next fetch address
   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_RET  = 2'd1,
      SEL_SEQ  = 2'd2,
      SEL_BR   = 2'd3
   } next_sel_t;

   localparam int DEFAULT_INC          = 4;
   localparam int DEFAULT_RESET_VECTOR = 0;

   // Ceiling log2, at least 1 so pointer vectors never collapse to zero width
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result = result + 1;
      if (result < 1) result = 1;
      return result;
   endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// rtl/pc_sequencer_return_stack.sv - circular return-address stack with push/pop/swap
module pc_sequencer_return_stack
   import pc_sequencer_pkg::*;
#(
   parameter int  W     = 32,
   parameter int  DEPTH = 4,
   localparam int PW    = clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         swap,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic [PW:0]  count,
   output logic         full,
   output logic         empty,
   output logic         overflow,
   output logic         underflow
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] ptr;        // next free slot; top lives one below
   logic [PW-1:0] top_idx;
   logic          swap_hit;
   logic          do_push;
   logic          do_pop;

   assign top_idx = ptr - PW'(1);
   assign top     = mem[top_idx];
   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));

   // A swap on an empty stack degenerates to a plain push
   assign swap_hit  = swap && !empty;
   assign do_push   = push || (swap && empty);
   assign do_pop    = pop && !swap && !empty;
   assign overflow  = do_push && full;
   assign underflow = (pop || swap) && empty;

   // Pointer and occupancy; a push while full wraps over the oldest entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
      end else if (swap_hit) begin
         ptr   <= ptr;
         count <= count;
      end else if (do_push) begin
         ptr <= ptr + PW'(1);
         if (!full) count <= count + (PW+1)'(1);
      end else if (do_pop) begin
         ptr   <= ptr - PW'(1);
         count <= count - (PW+1)'(1);
      end
   end

   // Entry storage; contents are meaningless while count is zero so no reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (swap_hit)     mem[top_idx] <= push_data;
         else if (do_push) mem[ptr]     <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with RAS; optional PC_ALIGN_CHECK_EN redirect alignment
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int          W            = 32,
   parameter int          INC          = DEFAULT_INC,
   parameter logic [W-1:0] RESET_VECTOR = W'(DEFAULT_RESET_VECTOR),
   parameter int          RAS_DEPTH    = 4,
   localparam int         PW           = clog2(RAS_DEPTH)
) (
   input  logic         clk,
   input  logic         reset_asynchronous,
   input  logic         stall,
   input  logic         branch_taken,
   input  logic [W-1:0] branch_target,
   input  logic         call,
   input  logic         ret,
   output logic [W-1:0] pc,
   output logic [W-1:0] pc_plus_inc,
   output logic         ras_empty,
   output logic         ras_full,
   output logic         ras_overflow,
   output logic         ras_underflow,
   output logic         misalign_fault
);

   next_sel_t    sel;
   logic         push;
   logic         pop;
   logic         swap;
   logic [W-1:0] ras_top;
   logic [PW:0]  ras_count;
   logic         stk_full;
   logic         stk_empty;
   logic         ovf_pulse;
   logic         unf_pulse;
   logic         has_entry;
   logic [W-1:0] redirect;
   logic [W-1:0] redirect_final;

   assign pc_plus_inc = pc + W'(INC);
   assign has_entry   = (ras_count != '0);
   assign ras_empty   = stk_empty;
   assign ras_full    = stk_full;

   pc_sequencer_return_stack #(
      .W     (W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (reset_asynchronous),
      .push      (push),
      .pop       (pop),
      .swap      (swap),
      .push_data (pc_plus_inc),
      .top       (ras_top),
      .count     (ras_count),
      .full      (stk_full),
      .empty     (stk_empty),
      .overflow  (ovf_pulse),
      .underflow (unf_pulse)
   );

   // Next-PC source and stack operation by priority: stall, ret, branch, sequential
   always_comb begin
      sel  = SEL_SEQ;
      push = 1'b0;
      pop  = 1'b0;
      swap = 1'b0;
      if (stall) begin
         sel = SEL_HOLD;
      end else if (ret) begin
         if (call && branch_taken) begin
            swap = 1'b1;
            sel  = has_entry ? SEL_RET : SEL_BR;
         end else begin
            pop = 1'b1;
            sel = has_entry ? SEL_RET : SEL_SEQ;
         end
      end else if (branch_taken) begin
         sel  = SEL_BR;
         push = call;
      end
   end

   assign redirect = (sel == SEL_RET) ? ras_top : branch_target;

`ifdef PC_ALIGN_CHECK_EN
   localparam int          ALIGN_BITS = clog2(INC);
   localparam logic [W-1:0] LOW_MASK  = (INC > 1) ? W'((1 << ALIGN_BITS) - 1) : '0;

   logic misaligned;

   assign misaligned     = ((sel == SEL_RET) || (sel == SEL_BR)) && ((redirect & LOW_MASK) != '0);
   assign redirect_final = redirect & ~LOW_MASK;

   // Sticky fault set by any accepted redirect with nonzero low bits
   always_ff @(posedge clk or posedge reset_asynchronous) begin
      if (reset_asynchronous) misalign_fault <= 1'b0;
      else if (misaligned)    misalign_fault <= 1'b1;
   end
`else
   assign redirect_final = redirect;
   assign misalign_fault = 1'b0;
`endif

   // Fetch PC register
   always_ff @(posedge clk or posedge reset_asynchronous) begin
      if (reset_asynchronous) begin
         pc <= RESET_VECTOR;
      end else begin
         case (sel)
            SEL_HOLD: pc <= pc;
            SEL_RET:  pc <= redirect_final;
            SEL_BR:   pc <= redirect_final;
            default:  pc <= pc_plus_inc;
         endcase
      end
   end

   // Sticky RAS error flags, cleared only by reset
   always_ff @(posedge clk or posedge reset_asynchronous) begin
      if (reset_asynchronous) begin
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         if (ovf_pulse) ras_overflow  <= 1'b1;
         if (unf_pulse) ras_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_asynchronous = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [31:0] pc;
   logic [31:0] pc_plus_inc;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_overflow;
   logic        ras_underflow;
   logic        misalign_fault;

   int total = 0;
   int bad = 0;

   pc_sequencer #(
      .W            (32),
      .INC          (4),
      .RESET_VECTOR (32'h100),
      .RAS_DEPTH    (4)
   ) dut (
      .clk                (clk),
      .reset_asynchronous (reset_asynchronous),
      .stall              (stall),
      .branch_taken       (branch_taken),
      .branch_target      (branch_target),
      .call               (call),
      .ret                (ret),
      .pc                 (pc),
      .pc_plus_inc        (pc_plus_inc),
      .ras_empty          (ras_empty),
      .ras_full           (ras_full),
      .ras_overflow       (ras_overflow),
      .ras_underflow      (ras_underflow),
      .misalign_fault     (misalign_fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic c, input logic r);
      stall = s;
      branch_taken = b;
      branch_target = t;
      call = c;
      ret = r;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h104;
      exp_pc[1] = 32'h108;
      exp_pc[2] = 32'h10C;
      #3;
      reset_asynchronous = 1'b1;
      #1;
      total++;
      if (pc !== 32'h100) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h100); end
      total++;
      if ({ras_empty, ras_full, ras_overflow, ras_underflow, misalign_fault} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=%b", {ras_empty, ras_full, ras_overflow, ras_underflow, misalign_fault}, 5'b10000);
      end
      step();
      total++;
      if (pc !== 32'h100) begin bad++; $display("FAIL reset_hold_pc got=%h exp=%h", pc, 32'h100); end
      reset_asynchronous = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (pc !== exp_pc[i]) begin bad++; $display("FAIL free_run_%0d got=%h exp=%h", i, pc, exp_pc[i]); end
      end
      total++;
      if (pc_plus_inc !== 32'h110) begin bad++; $display("FAIL pc_plus_inc got=%h exp=%h", pc_plus_inc, 32'h110); end
      total++;
      if (ras_empty !== 1'b1) begin bad++; $display("FAIL free_run_empty got=%b exp=1", ras_empty); end
   endtask

   task automatic test_call_ret();
      drive(0, 1, 32'h20, 0, 0); step();
      total++;
      if (pc !== 32'h20) begin bad++; $display("FAIL branch_pc got=%h exp=%h", pc, 32'h20); end
      drive(0, 1, 32'h80, 1, 0); step();
      total++;
      if (pc !== 32'h80 || ras_empty !== 1'b0) begin
         bad++; $display("FAIL call_pc got=%h empty=%b exp=%h empty=0", pc, ras_empty, 32'h80);
      end
      drive(0, 0, 32'h0, 0, 0); step();
      drive(0, 0, 32'h0, 0, 1); step();
      total++;
      if (pc !== 32'h24 || ras_empty !== 1'b1) begin
         bad++; $display("FAIL ret_pc got=%h empty=%b exp=%h empty=1", pc, ras_empty, 32'h24);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_pop [4];
      exp_pop[0] = 32'h14;
      exp_pop[1] = 32'h10;
      exp_pop[2] = 32'h0C;
      exp_pop[3] = 32'h08;
      drive(0, 1, 32'h0, 0, 0); step();
      for (int i = 1; i <= 5; i++) begin
         drive(0, 1, 32'(i * 4), 1, 0); step();
         if (i == 4) begin
            total++;
            if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin
               bad++; $display("FAIL full_at_4 full=%b ovf=%b exp full=1 ovf=0", ras_full, ras_overflow);
            end
         end
      end
      total++;
      if (ras_full !== 1'b1 || ras_overflow !== 1'b1 || pc !== 32'h14) begin
         bad++; $display("FAIL overflow full=%b ovf=%b pc=%h exp full=1 ovf=1 pc=00000014", ras_full, ras_overflow, pc);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 32'h0, 0, 1); step();
         total++;
         if (pc !== exp_pop[i]) begin bad++; $display("FAIL pop_%0d got=%h exp=%h", i, pc, exp_pop[i]); end
      end
      total++;
      if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
         bad++; $display("FAIL drained empty=%b unf=%b exp empty=1 unf=0", ras_empty, ras_underflow);
      end
      drive(0, 0, 32'h0, 0, 1); step();
      total++;
      if (pc !== 32'h0C || ras_underflow !== 1'b1) begin
         bad++; $display("FAIL underflow pc=%h unf=%b exp pc=0000000c unf=1", pc, ras_underflow);
      end
   endtask

   task automatic test_stall();
      drive(0, 1, 32'h40, 1, 0); step();
      drive(1, 1, 32'h200, 1, 1);
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (pc !== 32'h40 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
            bad++; $display("FAIL stall_%0d pc=%h empty=%b full=%b exp pc=00000040 empty=0 full=0", i, pc, ras_empty, ras_full);
         end
      end
      drive(0, 1, 32'h200, 0, 0); step();
      total++;
      if (pc !== 32'h200) begin bad++; $display("FAIL stall_release got=%h exp=%h", pc, 32'h200); end
      drive(0, 0, 32'h0, 0, 1); step();
      total++;
      if (pc !== 32'h10 || ras_empty !== 1'b1) begin
         bad++; $display("FAIL stall_ret pc=%h empty=%b exp pc=00000010 empty=1", pc, ras_empty);
      end
   endtask

   task automatic test_swap();
      drive(0, 1, 32'h300, 1, 0); step();
      drive(0, 1, 32'h400, 1, 1); step();
      total++;
      if (pc !== 32'h14 || ras_empty !== 1'b0) begin
         bad++; $display("FAIL swap_pc pc=%h empty=%b exp pc=00000014 empty=0", pc, ras_empty);
      end
      drive(0, 0, 32'h0, 0, 1); step();
      total++;
      if (pc !== 32'h304 || ras_empty !== 1'b1) begin
         bad++; $display("FAIL swap_top pc=%h empty=%b exp pc=00000304 empty=1", pc, ras_empty);
      end
      drive(0, 1, 32'h500, 1, 1); step();
      total++;
      if (pc !== 32'h500 || ras_empty !== 1'b0) begin
         bad++; $display("FAIL swap_empty pc=%h empty=%b exp pc=00000500 empty=0", pc, ras_empty);
      end
      drive(0, 0, 32'h0, 0, 1); step();
      total++;
      if (pc !== 32'h308) begin bad++; $display("FAIL swap_empty_ret got=%h exp=%h", pc, 32'h308); end
   endtask

   task automatic test_wrap();
      drive(0, 1, 32'hFFFF_FFFC, 0, 0); step();
      total++;
      if (pc_plus_inc !== 32'h0) begin bad++; $display("FAIL wrap_inc got=%h exp=%h", pc_plus_inc, 32'h0); end
      drive(0, 0, 32'h0, 0, 0); step();
      total++;
      if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
   endtask

   task automatic test_align();
      logic [31:0] exp_pc;
      logic        exp_fault;
`ifdef PC_ALIGN_CHECK_EN
      exp_pc = 32'h88;
      exp_fault = 1'b1;
`else
      exp_pc = 32'h8A;
      exp_fault = 1'b0;
`endif
      total++;
      if (misalign_fault !== 1'b0) begin bad++; $display("FAIL fault_before got=%b exp=0", misalign_fault); end
      drive(0, 1, 32'h8A, 0, 0); step();
      total++;
      if (pc !== exp_pc || misalign_fault !== exp_fault) begin
         bad++; $display("FAIL align pc=%h fault=%b exp pc=%h fault=%b", pc, misalign_fault, exp_pc, exp_fault);
      end
      drive(0, 0, 32'h0, 0, 0); step();
      total++;
      if (pc !== exp_pc + 32'h4 || misalign_fault !== exp_fault) begin
         bad++; $display("FAIL align_sticky pc=%h fault=%b exp pc=%h fault=%b", pc, misalign_fault, exp_pc + 32'h4, exp_fault);
      end
   endtask

   task automatic test_async_reset();
      drive(0, 1, 32'h600, 1, 0);
      #2;
      reset_asynchronous = 1'b1;
      #1;
      total++;
      if (pc !== 32'h100 || ras_empty !== 1'b1) begin
         bad++; $display("FAIL async_reset pc=%h empty=%b exp pc=00000100 empty=1", pc, ras_empty);
      end
      total++;
      if ({ras_overflow, ras_underflow, misalign_fault} !== 3'b000) begin
         bad++; $display("FAIL async_flags got=%b exp=000", {ras_overflow, ras_underflow, misalign_fault});
      end
      step();
      total++;
      if (pc !== 32'h100 || ras_empty !== 1'b1) begin
         bad++; $display("FAIL reset_edge pc=%h empty=%b exp pc=00000100 empty=1", pc, ras_empty);
      end
      drive(0, 0, 32'h0, 0, 0);
      reset_asynchronous = 1'b0;
      step();
      total++;
      if (pc !== 32'h104) begin bad++; $display("FAIL post_reset got=%h exp=%h", pc, 32'h104); end
   endtask

   initial begin
      test_reset();
      test_call_ret();
      test_overflow();
      test_stall();
      test_swap();
      test_wrap();
      test_align();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
